// File: rtl/sobel_edge.sv
// sobel_edge: streaming 3x3 Sobel gradient-magnitude stage.
//
// Consumes one 11-bit pixel per clock together with frame/line start strobes
// and produces an edge-strength stream in the same format, delayed by exactly
// three clocks. Two line buffers hold the previous two rows; a small column
// shift register completes the 3x3 window. The edge map is offset by (+1,+1)
// relative to the input because the window is centred on input (x-1, y-1).
//
// Ports:
//   Clk       rising-edge clock
//   nReset    synchronous active-low reset
//   PixelIn   input pixel, unsigned
//   FrameIn   strobe on pixel (0,0)
//   LineIn    strobe on pixel (0,y), y>=1
//   Width     active pixels per line (static during a frame)
//   Height    active lines per frame (static during a frame)
//   Bypass    per-pixel select: pass the delayed input through unfiltered
//   PixelOut  saturated edge magnitude (or delayed input in bypass)
//   FrameOut  FrameIn delayed 3 clocks
//   LineOut   LineIn delayed 3 clocks
module sobel_edge #(
    parameter int MAX_WIDTH = 256,
    parameter int SHIFT     = 3
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [10:0] PixelIn,
    input  logic        FrameIn,
    input  logic        LineIn,
    input  logic [7:0]  Width,
    input  logic [7:0]  Height,
    input  logic        Bypass,
    output logic [10:0] PixelOut,
    output logic        FrameOut,
    output logic        LineOut
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] RUN        = 1'b1;

    logic [0:0]    state;
    logic [7:0]    x_q, y_q;
    logic [7:0]    x_cur, y_cur;
    logic          active;
    logic          in_frame;
    logic          lb_we;
    logic [AW-1:0] addr;

    // Coordinate of the pixel currently on the input; the registers hold the
    // coordinate of the previous pixel. Outside RUN only FrameIn is honoured.
    always_comb begin
        active = (state == RUN) || FrameIn;
        x_cur  = x_q;
        y_cur  = y_q;
        if (FrameIn) begin
            x_cur = '0;
            y_cur = '0;
        end else if (state == RUN) begin
            if (LineIn) begin
                x_cur = '0;
                if (y_q < Height) begin
                    y_cur = y_q + 8'd1;
                end
            end else if (x_q != 8'hFF) begin
                x_cur = x_q + 8'd1;
            end
        end
        in_frame = (x_cur < Width) && (y_cur < Height);
        lb_we    = active && in_frame;
        addr     = x_cur[AW-1:0];
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state <= WAIT_FRAME;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            if (FrameIn) begin
                state <= RUN;
            end
            x_q <= x_cur;
            y_q <= y_cur;
        end
    end

    // Line buffers: lb1 = row y-1, lb2 = row y-2. Contents survive reset.
    // Registered read returns the old word even when the same address is
    // written on this edge, which is what shifts a row down by one.
    logic [10:0] lb1 [MAX_WIDTH];
    logic [10:0] lb2 [MAX_WIDTH];
    logic [10:0] rd_a, rd_b;

    always_ff @(posedge Clk) begin
        rd_b <= lb1[addr];
        rd_a <= lb2[addr];
        if (lb_we) begin
            lb1[addr] <= PixelIn;
            lb2[addr] <= lb1[addr];
        end
    end

    // Stage 1: current column (a,b from buffers, c = input) plus side-band.
    logic [10:0] s1_c;
    logic        s1_run, s1_byp, s1_zero, s1_frame, s1_line;

    // Columns x-1 (suffix 1) and x-2 (suffix 2) of rows a, b, c.
    logic [10:0] wa1, wa2, wb1, wb2, wc1, wc2;

    // Stage 2 results.
    logic [10:0] s2_pix, s2_mag;
    logic        s2_run, s2_byp, s2_zero, s2_frame, s2_line;

    logic [12:0] gx_p, gx_n, gy_p, gy_n;
    logic [12:0] gx_abs, gy_abs;
    logic [14:0] mag, mag_sh;
    logic [10:0] sat;

    // Gradients are formed as differences of two non-negative sums so the
    // absolute value needs no signed arithmetic.
    always_comb begin
        gx_p   = {2'b00, rd_a} + {1'b0, rd_b, 1'b0} + {2'b00, s1_c};
        gx_n   = {2'b00, wa2}  + {1'b0, wb2, 1'b0}  + {2'b00, wc2};
        gy_p   = {2'b00, wc2}  + {1'b0, wc1, 1'b0}  + {2'b00, s1_c};
        gy_n   = {2'b00, wa2}  + {1'b0, wa1, 1'b0}  + {2'b00, rd_a};
        gx_abs = (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
        gy_abs = (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
        mag    = {2'b00, gx_abs} + {2'b00, gy_abs};
        mag_sh = mag >> SHIFT;
        sat    = (mag_sh > 15'd2047) ? 11'h7FF : mag_sh[10:0];
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            s1_c     <= '0;
            s1_run   <= 1'b0;
            s1_byp   <= 1'b0;
            s1_zero  <= 1'b1;
            s1_frame <= 1'b0;
            s1_line  <= 1'b0;
            wa1      <= '0;
            wa2      <= '0;
            wb1      <= '0;
            wb2      <= '0;
            wc1      <= '0;
            wc2      <= '0;
            s2_pix   <= '0;
            s2_mag   <= '0;
            s2_run   <= 1'b0;
            s2_byp   <= 1'b0;
            s2_zero  <= 1'b1;
            s2_frame <= 1'b0;
            s2_line  <= 1'b0;
            PixelOut <= '0;
            FrameOut <= 1'b0;
            LineOut  <= 1'b0;
        end else begin
            // Stage 1
            s1_c     <= PixelIn;
            s1_run   <= active;
            s1_byp   <= Bypass;
            // Border rows/columns and out-of-frame pixels never use the window.
            s1_zero  <= !in_frame || (x_cur < 8'd2) || (y_cur < 8'd2);
            s1_frame <= FrameIn;
            s1_line  <= LineIn && active;

            // Column history, shifted every cycle.
            wa1 <= rd_a;
            wa2 <= wa1;
            wb1 <= rd_b;
            wb2 <= wb1;
            wc1 <= s1_c;
            wc2 <= wc1;

            // Stage 2
            s2_pix   <= s1_c;
            s2_mag   <= sat;
            s2_run   <= s1_run;
            s2_byp   <= s1_byp;
            s2_zero  <= s1_zero;
            s2_frame <= s1_frame;
            s2_line  <= s1_line;

            // Stage 3
            FrameOut <= s2_frame;
            LineOut  <= s2_line;
            if (!s2_run) begin
                PixelOut <= '0;
            end else if (s2_byp) begin
                PixelOut <= s2_pix;
            end else if (s2_zero) begin
                PixelOut <= '0;
            end else begin
                PixelOut <= s2_mag;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: drives three sobel_edge instances (SHIFT = 0, 2, 3) with one
// shared stream and compares each cycle against an image-level model that
// stores the frame in a 2-D array and evaluates the Sobel formulas directly.
module tb_sobel_edge;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [10:0] PixelIn = '0;
    logic        FrameIn = 1'b0;
    logic        LineIn = 1'b0;
    logic [7:0]  Width = 8'd8;
    logic [7:0]  Height = 8'd6;
    logic        Bypass = 1'b0;

    logic [10:0] po0, po2, po3;
    logic        fo0, fo2, fo3, lo0, lo2, lo3;

    sobel_edge #(.MAX_WIDTH(256), .SHIFT(0)) dut0 (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
        .LineIn(LineIn), .Width(Width), .Height(Height), .Bypass(Bypass),
        .PixelOut(po0), .FrameOut(fo0), .LineOut(lo0));

    sobel_edge #(.MAX_WIDTH(256), .SHIFT(2)) dut2 (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
        .LineIn(LineIn), .Width(Width), .Height(Height), .Bypass(Bypass),
        .PixelOut(po2), .FrameOut(fo2), .LineOut(lo2));

    sobel_edge #(.MAX_WIDTH(256), .SHIFT(3)) dut3 (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
        .LineIn(LineIn), .Width(Width), .Height(Height), .Bypass(Bypass),
        .PixelOut(po3), .FrameOut(fo3), .LineOut(lo3));

    always #5 Clk = ~Clk;

    localparam int NCYC = 4096;

    // Expected {PixelOut, FrameOut, LineOut} per observation cycle.
    logic [12:0] exp0 [NCYC];
    logic [12:0] exp2 [NCYC];
    logic [12:0] exp3 [NCYC];
    logic        exp_ok [NCYC];

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    // Model state
    int          m_run = 0;
    int          m_x = 0;
    int          m_y = 0;
    int          nxt_w = 8;
    int          nxt_h = 6;
    logic [10:0] img [256][256];

    function automatic int px(input int x, input int y);
        return int'(img[y][x]);
    endfunction

    function automatic int sobel_mag(input int x, input int y);
        int gx, gy;
        gx = (px(x, y-2) - px(x-2, y-2)) + 2 * (px(x, y-1) - px(x-2, y-1))
           + (px(x, y) - px(x-2, y));
        gy = (px(x-2, y) + 2 * px(x-1, y) + px(x, y))
           - (px(x-2, y-2) + 2 * px(x-1, y-2) + px(x, y-2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    function automatic logic [10:0] clip(input int m, input int sh);
        int v;
        v = m >> sh;
        if (v > 2047) return 11'd2047;
        return v[10:0];
    endfunction

    task automatic check_one(input string tag, input logic [12:0] got, input logic [12:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed pix=%0d frame=%b line=%b expected pix=%0d frame=%b line=%b",
                   tag, cyc, got[12:2], got[1], got[0], want[12:2], want[1], want[0]);
        end
    endtask

    // One clock: check what the DUTs show now, apply the next input, and let
    // the model predict what appears three clocks later.
    task automatic step(input logic [10:0] p, input logic f, input logic l,
                        input logic byp, input logic rn);
        logic [10:0] e0, e2, e3;
        logic        ef, el;
        int          act, inf, m;
        @(negedge Clk);
        if (exp_ok[cyc]) begin
            check_one("shift0", {po0, fo0, lo0}, exp0[cyc]);
            check_one("shift2", {po2, fo2, lo2}, exp2[cyc]);
            check_one("shift3", {po3, fo3, lo3}, exp3[cyc]);
        end
        PixelIn = p;
        FrameIn = f;
        LineIn  = l;
        Bypass  = byp;
        nReset  = rn;
        Width   = 8'(nxt_w);
        Height  = 8'(nxt_h);
        if (cyc + 3 >= NCYC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
            $fatal(1, "cycle budget exhausted");
        end
        e0 = '0; e2 = '0; e3 = '0; ef = 1'b0; el = 1'b0;
        if (!rn) begin
            m_run = 0; m_x = 0; m_y = 0;
            for (int k = 1; k <= 3; k++) begin
                exp0[cyc+k] = '0; exp2[cyc+k] = '0; exp3[cyc+k] = '0;
                exp_ok[cyc+k] = 1'b1;
            end
        end else begin
            act = (m_run != 0 || f) ? 1 : 0;
            if (f) begin
                m_run = 1; m_x = 0; m_y = 0;
            end else if (m_run != 0) begin
                if (l) begin
                    m_x = 0;
                    if (m_y < nxt_h) m_y++;
                end else if (m_x < 255) begin
                    m_x++;
                end
            end
            inf = (act != 0 && m_x < nxt_w && m_y < nxt_h) ? 1 : 0;
            if (inf != 0) img[m_y][m_x] = p;
            if (act != 0) begin
                ef = f;
                el = l;
                if (byp) begin
                    e0 = p; e2 = p; e3 = p;
                end else if (inf != 0 && m_x >= 2 && m_y >= 2) begin
                    m  = sobel_mag(m_x, m_y);
                    e0 = clip(m, 0); e2 = clip(m, 2); e3 = clip(m, 3);
                end
            end
            exp0[cyc+3] = {e0, ef, el};
            exp2[cyc+3] = {e2, ef, el};
            exp3[cyc+3] = {e3, ef, el};
            exp_ok[cyc+3] = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(11'($urandom_range(0, 2047)), 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // mode: 0 constant lo, 1 vertical step at x>=4, 2 horizontal step at y>=3,
    //       3 ramp x+10y, 4 random. bmode: 0 off, 1 on, 2 random per pixel.
    // limit < 0 sends the whole frame, otherwise stops after that many pixels.
    task automatic send_frame(input int w, input int h, input int len, input int nlines,
                              input int mode, input int lo, input int hi,
                              input int bmode, input int limit);
        int          cnt;
        logic [10:0] p;
        logic        b;
        nxt_w = w;
        nxt_h = h;
        cnt = 0;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < len; x++) begin
                if (limit >= 0 && cnt >= limit) return;
                case (mode)
                    0:       p = 11'(lo);
                    1:       p = (x >= 4) ? 11'(hi) : 11'(lo);
                    2:       p = (y >= 3) ? 11'(hi) : 11'(lo);
                    3:       p = 11'(x + 10 * y);
                    default: p = 11'($urandom_range(0, 2047));
                endcase
                b = (bmode == 1) ? 1'b1 : (bmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                step(p, (x == 0 && y == 0), (x == 0 && y > 0), b, 1'b1);
                cnt++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) exp_ok[i] = 1'b0;

        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Flat frame
        send_frame(8, 6, 8, 6, 0, 500, 500, 0, -1);
        idle(4);
        // Vertical step
        send_frame(8, 6, 8, 6, 1, 0, 100, 0, -1);
        idle(4);
        // Saturating vertical step
        send_frame(8, 6, 8, 6, 1, 0, 2047, 0, -1);
        idle(4);
        // Horizontal step
        send_frame(8, 6, 8, 6, 2, 0, 200, 0, -1);
        idle(4);

        // Reset during line 3, then LineIn pulses with no FrameIn
        send_frame(8, 6, 8, 6, 1, 0, 100, 0, 27);
        step(11'd77, 1'b0, 1'b0, 1'b0, 1'b0);
        step(11'd78, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(11'($urandom_range(0, 2047)), 1'b0, (i % 5 == 0), 1'($urandom_range(0, 1)), 1'b1);
        send_frame(8, 6, 8, 6, 1, 0, 100, 0, -1);
        idle(4);

        // Bypass ramp, then overrun lines with Width=4
        send_frame(8, 6, 8, 6, 3, 0, 0, 1, -1);
        idle(4);
        send_frame(4, 6, 6, 6, 4, 0, 0, 0, -1);
        idle(4);

        // Random frames: random sizes, overlong lines, extra line past Height
        for (int f = 0; f < 3; f++) begin
            int w, h;
            w = $urandom_range(3, 24);
            h = $urandom_range(3, 12);
            send_frame(w, h, w + $urandom_range(0, 2), h + 1, 4, 0, 0, (f == 1) ? 2 : 0, -1);
            idle(5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sobel_edge.md
Name: sobel_edge

Overview:
- Streaming 3x3 Sobel gradient-magnitude stage. It sits directly upstream of the circle-detection stage and turns the raw 11-bit pixel stream into an edge-strength stream.
- Input and output use the same stream format: one pixel per clock, plus FrameIn/LineIn start strobes.
- Two internal line buffers provide the 3x3 window.
- The output stream is timing-aligned with the input, delayed by a fixed 3 cycles.

Parameters:
- MAX_WIDTH, 256, depth of each line buffer; runtime Width must be <= MAX_WIDTH.
- SHIFT, 3, right-shift applied to the raw magnitude before saturation.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- nReset  input  1  synchronous, active-low reset, sampled on rising Clk.
- PixelIn  input  11  input pixel, unsigned.
- FrameIn  input  1  high for the single cycle carrying pixel (0,0).
- LineIn  input  1  high for the cycle carrying pixel (0,y), y>=1.
- Width  input  8  active pixels per line; held static during a frame.
- Height  input  8  active lines per frame; held static during a frame.
- Bypass  input  1  when 1, output is the delayed input pixel with no filtering.
- PixelOut  output  11  edge magnitude, unsigned, saturated.
- FrameOut  output  1  FrameIn delayed 3 cycles.
- LineOut  output  1  LineIn delayed 3 cycles.

Behaviour:
- **Reset (nReset low at a rising edge):**
  - PixelOut=0, FrameOut=0, LineOut=0.
  - Internal 3-stage delay pipeline cleared; x=0, y=0; state=WAIT_FRAME.
  - Line buffer contents are not reset.
  - Reset asserted mid-frame aborts the frame immediately.
- **State machine:**
  - WAIT_FRAME: PixelOut is forced to 0, FrameOut/LineOut stay 0, and LineIn is ignored. FrameIn moves to RUN on the same edge.
  - RUN: normal operation, with no exit except reset.
  - FrameIn while in RUN restarts the frame: x=0, y=0.
- **Counters (track the coordinate of the current input pixel):**
  - FrameIn -> (0,0).
  - LineIn -> x=0, y=y+1.
  - Otherwise x=x+1, saturating at 255.
  - If y reaches Height, y holds; the pixel is out-of-frame.
- **Line buffers:**
  - LB1 holds row y-1 and LB2 holds row y-2, both indexed by x.
  - Each cycle with x<Width: read LB1[x] and LB2[x] (old data), write LB2[x]<=LB1[x] and LB1[x]<=PixelIn.
  - Read-before-write at the same address is required.
  - Pixels with x>=Width or y>=Height: buffers are not written and the output pixel is 0.
- **Window:** 3x3 of rows {y-2, y-1, y} and columns {x-2, x-1, x}, centred on input (x-1, y-1). The edge map is therefore offset by (+1,+1); this offset is intentional and downstream accounts for it.
- **Arithmetic:**
  - Gx = (a[x]-a[x-2]) + 2(b[x]-b[x-2]) + (c[x]-c[x-2]), where a=row y-2, b=row y-1, c=row y.
  - Gy = (c[x-2]+2c[x-1]+c[x]) - (a[x-2]+2a[x-1]+a[x]).
  - Each gradient is 14-bit signed, range ±8188.
  - M = |Gx|+|Gy|, 15-bit unsigned (max 16376).
  - PixelOut = min(M>>SHIFT, 2047).
- **Border:** output is 0 where x<2 or y<2; stale window/buffer data must never leak into the output.
- **Latency:**
  - Exactly 3 cycles from an input pixel to its output and its FrameOut/LineOut.
  - The 3-cycle pipeline is free-running: no stalls, no backpressure.
- **Bypass:**
  - PixelOut = PixelIn delayed 3 cycles, unmodified; borders not zeroed.
  - State, counters and line buffers keep updating, so toggling Bypass between frames needs no resynchronisation.
  - WAIT_FRAME forcing still applies.
  - Bypass is sampled per pixel at input time and delayed with the pixel.

Test Plan:
1. **Flat frame:** Width=8, Height=6, all pixels 500, SHIFT=3, after reset.
   - Every PixelOut=0.
   - FrameOut high exactly 3 cycles after FrameIn.
   - LineOut pulses 3 cycles after each of the 5 LineIn pulses.
2. **Vertical step:** Width=8, Height=6, SHIFT=0; columns x<=3 = 0, x>=4 = 100.
   - Output positions (4,y) and (5,y) for y>=2 equal 400.
   - All other positions equal 0, including rows 0-1 and columns 0-1.
3. **Saturation:** same step with values 0/2047.
   - SHIFT=0: step positions output 2047 (raw 8188 clipped).
   - SHIFT=3: step positions output 1023.
4. **Horizontal step:** Width=8, Height=6, SHIFT=2; rows y<=2 = 0, rows y>=3 = 200.
   - Rows y=3 and y=4, columns x>=2, output 200 (raw 800>>2).
   - All other positions 0.
5. **Reset mid-frame:** nReset low for 2 cycles during line 3, then LineIn pulses but no FrameIn for 20 cycles.
   - PixelOut, FrameOut and LineOut are 0 from the first reset edge until 3 cycles after the next FrameIn.
   - The following frame output matches scenario 2.
6. **Bypass and overrun:**
   - Bypass=1, ramp PixelIn=x+10y: PixelOut equals the ramp delayed 3 cycles, borders included.
   - Bypass=0, Width=4 with a 6-pixel line: PixelOut=0 for x=4,5, and LB contents at x<4 are unaffected (checked on the next line's output).
